cache_refill_arbiter: RTL and testbench

Shares the single external memory port between the instruction-cache and data-cache miss handlers. Each granted request runs a fixed-length burst of aligned word transfers. The block produces the per-requester done pulses and the stall levels that freeze the pipeline registers, including the MEM/WB `cache_stall` input, while a miss is outstanding. It sits between the two caches and the memory bus controller.

---
 rtl/cache_refill_arbiter_if.sv | 40 ++++
 rtl/cache_refill_arbiter.sv | 94 +++++++++
 tb/tb_cache_refill_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_arbiter_if.sv
// Cache-side and memory-side signals of the refill arbiter.
// The arbiter uses the master modport; the caches and memory controller use the slave modport.
interface cache_refill_arbiter_if #(
    parameter int unsigned BURST_WORDS = 4
);
    localparam int unsigned IDX_W = $clog2(BURST_WORDS);

    logic             ic_req;
    logic [31:0]      ic_addr;
    logic             dc_req;
    logic             dc_we;
    logic [31:0]      dc_addr;
    logic [31:0]      dc_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_ready;
    logic             mem_cs;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [IDX_W-1:0] word_idx;
    logic             ic_rvalid;
    logic             dc_rvalid;
    logic             ic_done;
    logic             dc_done;
    logic             if_stall;
    logic             mem_stall;

    // mem_rdata travels straight from memory to both caches, qualified by the rvalids.
    modport master (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready,
        output mem_cs, mem_we, mem_addr, mem_wdata, word_idx,
               ic_rvalid, dc_rvalid, ic_done, dc_done, if_stall, mem_stall
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
        input  mem_cs, mem_we, mem_addr, mem_wdata, word_idx,
               ic_rvalid, dc_rvalid, ic_done, dc_done, if_stall, mem_stall
    );
endinterface

// File: rtl/cache_refill_arbiter.sv
// Arbitrates the external memory port between I-cache refills and D-cache refill/write-back
// bursts, producing done pulses and pipeline stall levels.
module cache_refill_arbiter #(
    parameter int unsigned BURST_WORDS = 4
) (
    input logic                    clock,
    input logic                    reset,
    cache_refill_arbiter_if.master bus
);
    localparam int unsigned IDX_W    = $clog2(BURST_WORDS);
    localparam logic [31:0] LOW_MASK = 32'(BURST_WORDS * 4 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IC_BURST,
        S_DC_BURST,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_last_dc;
    logic             r_mem_cs;
    logic             r_mem_we;
    logic             r_ic_done;
    logic             r_dc_done;
    logic [IDX_W-1:0] r_word_idx;
    logic [31:0]      r_base;

    logic             w_grant_dc;
    logic             w_last_word;

    // On a tie the requester that did not own the previous burst wins.
    assign w_grant_dc  = bus.dc_req & (~bus.ic_req | ~r_last_dc);
    assign w_last_word = (r_word_idx == IDX_W'(BURST_WORDS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_dc  <= 1'b0;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_ic_done  <= 1'b0;
            r_dc_done  <= 1'b0;
            r_word_idx <= '0;
            r_base     <= '0;
        end else begin
            r_ic_done <= 1'b0;
            r_dc_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ic_req | bus.dc_req) begin
                        r_state    <= w_grant_dc ? S_DC_BURST : S_IC_BURST;
                        r_last_dc  <= w_grant_dc;
                        r_base     <= (w_grant_dc ? bus.dc_addr : bus.ic_addr) & ~LOW_MASK;
                        r_word_idx <= '0;
                        r_mem_cs   <= 1'b1;
                        r_mem_we   <= w_grant_dc & bus.dc_we;
                    end
                end
                S_IC_BURST, S_DC_BURST: begin
                    if (bus.mem_ready) begin
                        // Power-of-two burst length makes the increment wrap to 0 on the last word.
                        r_word_idx <= r_word_idx + IDX_W'(1);
                        if (w_last_word) begin
                            r_state   <= S_DONE;
                            r_mem_cs  <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_ic_done <= ~r_last_dc;
                            r_dc_done <= r_last_dc;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cs    = r_mem_cs;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_base | (32'(r_word_idx) << 2);
    assign bus.mem_wdata = bus.dc_wdata;
    assign bus.word_idx  = r_word_idx;
    assign bus.ic_rvalid = bus.mem_ready & (r_state == S_IC_BURST);
    assign bus.dc_rvalid = bus.mem_ready & (r_state == S_DC_BURST) & ~r_mem_we;
    assign bus.ic_done   = r_ic_done;
    assign bus.dc_done   = r_dc_done;
    assign bus.if_stall  = bus.ic_req & ~r_ic_done;
    assign bus.mem_stall = bus.dc_req & ~r_dc_done;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Self-checking bench for cache_refill_arbiter: directed scenarios plus randomized bursts
// checked against a transaction-level expectation of grant order, addresses and timing.
module tb_cache_refill_arbiter;
    localparam int unsigned BW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_last_dc = 1'b0;
    logic        wb_mode = 1'b0;
    logic [31:0] wdata_rand = '0;
    logic [7:0]  ctl;

    cache_refill_arbiter_if #(.BURST_WORDS(BW)) bus();

    cache_refill_arbiter #(.BURST_WORDS(BW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Write-back source: the cache returns 0xA0 + word_idx in write-back mode.
    always_comb bus.dc_wdata = wb_mode ? (32'hA0 + 32'(bus.word_idx)) : wdata_rand;

    assign ctl = {bus.mem_cs, bus.mem_we, bus.ic_rvalid, bus.dc_rvalid,
                  bus.ic_done, bus.dc_done, bus.if_stall, bus.mem_stall};

    function automatic logic [7:0] pack(input logic cs, input logic we, input logic icv,
                                        input logic dcv, input logic icd, input logic dcd,
                                        input logic ifs, input logic ms);
        return {cs, we, icv, dcv, icd, dcd, ifs, ms};
    endfunction

    task automatic test_reset();
        bus.ic_req = 1'b1;
        #1;
        n_cmp++; if (ctl !== 8'b0000_0010) begin n_bad++; $display("FAIL rst_ctl got %b want 00000010", ctl); end
        n_cmp++; if ({bus.mem_addr, bus.word_idx} !== '0) begin n_bad++; $display("FAIL rst_addr got %h/%0d want 0/0", bus.mem_addr, bus.word_idx); end
        bus.ic_req = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clock); @(negedge clock); #1;
        n_cmp++; if (ctl !== 8'b0) begin n_bad++; $display("FAIL rst_held got %b want 00000000", ctl); end
        bus.mem_ready = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia = 32'h0000_5A7C;
        logic [31:0] da = 32'h4000_0318;
        logic [31:0] base;
        logic        dc_own;
        bus.ic_addr = ia; bus.dc_addr = da; bus.dc_we = 1'b0;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1; bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (ctl !== 8'b0000_0011) begin n_bad++; $display("FAIL b2b_latency got %b want 00000011", ctl); end
        for (int g = 0; g < 4; g++) begin
            dc_own = (g % 2 == 0);
            base = (dc_own ? da : ia) & ~32'(BW * 4 - 1);
            for (int k = 0; k < int'(BW); k++) begin
                @(negedge clock); #1;
                n_cmp++; if (ctl !== pack(1'b1, 1'b0, !dc_own, dc_own, 1'b0, 1'b0, 1'b1, 1'b1)) begin
                    n_bad++; $display("FAIL b2b_ctl g=%0d k=%0d got %b want owner_dc=%0d", g, k, ctl, dc_own);
                end
                n_cmp++; if (bus.mem_addr !== base + 32'(4 * k)) begin
                    n_bad++; $display("FAIL b2b_addr g=%0d k=%0d got %h want %h", g, k, bus.mem_addr, base + 32'(4 * k));
                end
            end
            @(negedge clock); #1;
            n_cmp++; if (ctl !== pack(1'b0, 1'b0, 1'b0, 1'b0, !dc_own, dc_own, dc_own, !dc_own)) begin
                n_bad++; $display("FAIL b2b_done g=%0d got %b owner_dc=%0d", g, ctl, dc_own);
            end
            @(negedge clock); #1;
            n_cmp++; if (ctl !== 8'b0000_0011) begin n_bad++; $display("FAIL b2b_gap g=%0d got %b want 00000011", g, ctl); end
        end
        bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.mem_ready = 1'b0;
        m_last_dc = 1'b0;
    endtask

    task automatic test_ic_refill();
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1234; bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (ctl !== 8'b0000_0010) begin n_bad++; $display("FAIL ic_idle_ready got %b want 00000010", ctl); end
        for (int k = 0; k < int'(BW); k++) begin
            @(negedge clock); #1;
            n_cmp++; if (ctl !== 8'b1010_0010) begin n_bad++; $display("FAIL ic_ctl k=%0d got %b want 10100010", k, ctl); end
            n_cmp++; if ({bus.mem_addr, 32'(bus.word_idx)} !== {32'h1230 + 32'(4 * k), 32'(k)}) begin
                n_bad++; $display("FAIL ic_addr k=%0d got %h/%0d want %h/%0d", k, bus.mem_addr, bus.word_idx, 32'h1230 + 32'(4 * k), k);
            end
        end
        @(negedge clock); #1;
        n_cmp++; if (ctl !== 8'b0000_1000) begin n_bad++; $display("FAIL ic_done got %b want 00001000", ctl); end
        bus.ic_req = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clock); #1;
        n_cmp++; if (ctl !== 8'b0) begin n_bad++; $display("FAIL ic_after got %b want 00000000", ctl); end
        m_last_dc = 1'b0;
    endtask

    task automatic test_writeback();
        wb_mode = 1'b1;
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 32'h8000_0040; bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (ctl !== 8'b0000_0001) begin n_bad++; $display("FAIL wb_idle got %b want 00000001", ctl); end
        for (int k = 0; k < int'(BW); k++) begin
            @(negedge clock); #1;
            n_cmp++; if (ctl !== 8'b1100_0001) begin n_bad++; $display("FAIL wb_ctl k=%0d got %b want 11000001", k, ctl); end
            n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h8000_0040 + 32'(4 * k), 32'hA0 + 32'(k)}) begin
                n_bad++; $display("FAIL wb_data k=%0d got %h:%h want %h:%h", k, bus.mem_addr, bus.mem_wdata, 32'h8000_0040 + 32'(4 * k), 32'hA0 + 32'(k));
            end
        end
        @(negedge clock); #1;
        n_cmp++; if (ctl !== 8'b0000_0100) begin n_bad++; $display("FAIL wb_done got %b want 00000100", ctl); end
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.mem_ready = 1'b0; wb_mode = 1'b0;
        @(negedge clock); #1;
        n_cmp++; if (ctl !== 8'b0) begin n_bad++; $display("FAIL wb_after got %b want 00000000", ctl); end
        m_last_dc = 1'b1;
    endtask

    task automatic test_wait_states();
        logic [31:0] base;
        int          words = 0;
        bus.dc_addr = $urandom; bus.dc_we = 1'b0; bus.dc_req = 1'b1; bus.mem_ready = 1'b0;
        base = bus.dc_addr & ~32'(BW * 4 - 1);
        #1;
        for (int c = 0; c < 3 * int'(BW); c++) begin
            @(negedge clock);
            bus.mem_ready = (c % 3 == 2);
            #1;
            n_cmp++; if (ctl !== pack(1'b1, 1'b0, 1'b0, bus.mem_ready, 1'b0, 1'b0, 1'b0, 1'b1)) begin
                n_bad++; $display("FAIL ws_ctl c=%0d got %b ready=%b", c, ctl, bus.mem_ready);
            end
            n_cmp++; if ({bus.mem_addr, 32'(bus.word_idx)} !== {base + 32'(4 * words), 32'(words)}) begin
                n_bad++; $display("FAIL ws_addr c=%0d got %h/%0d want %h/%0d", c, bus.mem_addr, bus.word_idx, base + 32'(4 * words), words);
            end
            if (bus.mem_ready) words++;
        end
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (ctl !== 8'b0000_0100) begin n_bad++; $display("FAIL ws_done got %b want 00000100", ctl); end
        bus.dc_req = 1'b0;
        @(negedge clock); #1;
        m_last_dc = 1'b1;
    endtask

    task automatic test_reset_midburst();
        logic [31:0] base;
        bus.ic_addr = $urandom; bus.ic_req = 1'b1; bus.mem_ready = 1'b1;
        base = bus.ic_addr & ~32'(BW * 4 - 1);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            n_cmp++; if (bus.mem_addr !== base + 32'(4 * k)) begin
                n_bad++; $display("FAIL rmb_pre k=%0d got %h want %h", k, bus.mem_addr, base + 32'(4 * k));
            end
        end
        reset = 1'b1;
        #1;
        n_cmp++; if ({ctl, 32'(bus.word_idx)} !== {8'b0000_0010, 32'd0}) begin
            n_bad++; $display("FAIL rmb_drop got %b/%0d want 00000010/0", ctl, bus.word_idx);
        end
        @(negedge clock); #1;
        n_cmp++; if (ctl !== 8'b0000_0010) begin n_bad++; $display("FAIL rmb_nodone got %b want 00000010", ctl); end
        reset = 1'b0;
        for (int k = 0; k < int'(BW); k++) begin
            @(negedge clock); #1;
            n_cmp++; if ({ctl, bus.mem_addr} !== {8'b1010_0010, base + 32'(4 * k)}) begin
                n_bad++; $display("FAIL rmb_restart k=%0d got %b/%h want 10100010/%h", k, ctl, bus.mem_addr, base + 32'(4 * k));
            end
        end
        @(negedge clock); #1;
        n_cmp++; if (ctl !== 8'b0000_1000) begin n_bad++; $display("FAIL rmb_done got %b want 00001000", ctl); end
        bus.ic_req = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clock); #1;
        m_last_dc = 1'b0;
    endtask

    task automatic test_random(input int n_bursts);
        logic        ic, dc, we, dc_own, exp_we, r;
        logic [31:0] ia, da, base;
        int          words, cyc, drop_at;
        for (int b = 0; b < n_bursts; b++) begin
            ic = 1'($urandom_range(0, 1));
            dc = 1'($urandom_range(0, 1));
            if (!ic && !dc) ic = 1'b1;
            ia = $urandom; da = $urandom; we = 1'($urandom_range(0, 1));
            bus.ic_req = ic; bus.dc_req = dc; bus.ic_addr = ia; bus.dc_addr = da; bus.dc_we = we;
            bus.mem_ready = 1'($urandom_range(0, 1));
            dc_own = dc && (!ic || !m_last_dc);
            exp_we = dc_own && we;
            base = (dc_own ? da : ia) & ~32'(BW * 4 - 1);
            #1;
            n_cmp++; if (ctl !== pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ic, dc)) begin
                n_bad++; $display("FAIL rnd_idle b=%0d got %b", b, ctl);
            end
            words = 0; cyc = 0;
            drop_at = int'($urandom_range(0, 3 * BW));
            while (words < int'(BW)) begin
                @(negedge clock);
                if (cyc == drop_at) begin
                    if (dc_own) dc = 1'b0; else ic = 1'b0;
                    bus.ic_req = ic; bus.dc_req = dc;
                end
                r = ($urandom_range(0, 2) != 0);
                bus.mem_ready = r; wdata_rand = $urandom; bus.mem_rdata = $urandom;
                #1;
                n_cmp++; if (ctl !== pack(1'b1, exp_we, r && !dc_own, r && dc_own && !exp_we, 1'b0, 1'b0, ic, dc)) begin
                    n_bad++; $display("FAIL rnd_ctl b=%0d w=%0d got %b owner_dc=%0d we=%0d", b, words, ctl, dc_own, exp_we);
                end
                n_cmp++; if ({bus.mem_addr, 32'(bus.word_idx), bus.mem_wdata} !== {base + 32'(4 * words), 32'(words), wdata_rand}) begin
                    n_bad++; $display("FAIL rnd_addr b=%0d got %h/%0d/%h want %h/%0d/%h", b, bus.mem_addr, bus.word_idx, bus.mem_wdata, base + 32'(4 * words), words, wdata_rand);
                end
                if (r) words++;
                cyc++;
                if (cyc > 20 * int'(BW)) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rnd_timeout b=%0d got %0d words want %0d", b, words, BW);
                    break;
                end
            end
            @(negedge clock);
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            n_cmp++; if (ctl !== pack(1'b0, 1'b0, 1'b0, 1'b0, !dc_own, dc_own, ic && dc_own, dc && !dc_own)) begin
                n_bad++; $display("FAIL rnd_done b=%0d got %b owner_dc=%0d", b, ctl, dc_own);
            end
            bus.ic_req = 1'b0; bus.dc_req = 1'b0;
            @(negedge clock); #1;
            n_cmp++; if (ctl !== 8'b0) begin n_bad++; $display("FAIL rnd_gap b=%0d got %b want 00000000", b, ctl); end
            m_last_dc = dc_own;
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        bus.ic_req = 1'b0; bus.ic_addr = '0; bus.dc_req = 1'b0; bus.dc_we = 1'b0;
        bus.dc_addr = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_back_to_back();
        test_ic_refill();
        test_writeback();
        test_wait_states();
        test_reset_midburst();
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1);
    end
endmodule
